// File: rtl/nivelcarga_if.sv
// Board-facing bundle of the charge-level monitor.
// All pins are active-low.
//   nivel_n    : N channel levels, W bits each; true level = ~bits
//   mute_n     : mute button, level signal
//   green_n    : GREEN LED
//   yellow_n   : YELLOW LED
//   critical_n : CRITICAL LED
//   descarga_n : per-channel discharge alert
//   buzzer_n   : buzzer drive
//   estado     : debug state code (0=GREEN, 1=YELLOW, 2=CRITICAL); not inverted
// The master drives the switches; the slave (the monitor) drives LEDs and buzzer.
interface nivelcarga_if #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 4
);
   logic [N*W-1:0] nivel_n;
   logic           mute_n;
   logic           green_n;
   logic           yellow_n;
   logic           critical_n;
   logic [N-1:0]   descarga_n;
   logic           buzzer_n;
   logic [1:0]     estado;

   modport master (
      output nivel_n, mute_n,
      input  green_n, yellow_n, critical_n, descarga_n, buzzer_n, estado
   );

   modport slave (
      input  nivel_n, mute_n,
      output green_n, yellow_n, critical_n, descarga_n, buzzer_n, estado
   );
endinterface

// File: rtl/nivelcarga_monitor.sv
// Clocked N-channel battery charge monitor.
// Sums the registered channel levels and classifies the total as GREEN / YELLOW / CRITICAL
// with hysteresis on improving moves and a DEB-cycle persistence filter. Each channel has
// its own filtered discharge alert. In CRITICAL a buzzer pulses BUZ_HALF low / BUZ_HALF
// high until muted by a falling edge of mute_n.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : nivelcarga_if slave modport (switch inputs, LEDs, buzzer, debug state)
module nivelcarga_monitor #(
   parameter int unsigned N        = 2,
   parameter int unsigned W        = 4,
   parameter int unsigned TH_G     = 16,
   parameter int unsigned TH_C     = 8,
   parameter int unsigned TH_D     = 3,
   parameter int unsigned HYST     = 2,
   parameter int unsigned DEB      = 4,
   parameter int unsigned BUZ_HALF = 8
) (
   input logic        clk,
   input logic        rst_n,
   nivelcarga_if.slave bus
);
   localparam int unsigned SW = W + $clog2(N) + 1;
   localparam int unsigned CW = $clog2(DEB + 1);
   localparam int unsigned PW = $clog2(2 * BUZ_HALF);

   localparam logic [SW-1:0] ThG   = SW'(TH_G);
   localparam logic [SW-1:0] ThGUp = SW'(TH_G + HYST);
   localparam logic [SW-1:0] ThC   = SW'(TH_C);
   localparam logic [SW-1:0] ThCUp = SW'(TH_C + HYST);
   localparam logic [SW-1:0] ThD   = SW'(TH_D);
   localparam logic [SW-1:0] ThDUp = SW'(TH_D + HYST);

   typedef enum logic [1:0] {StGreen = 2'd0, StYellow = 2'd1, StCrit = 2'd2} state_e;

   // Input stage; pins at reset value 0 mean every channel is full.
   logic [N*W-1:0] nivel_q;
   logic           mute_q, mute_prev_q;

   state_e          state_q, state_d, target, cand_q, cand_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    alert_q, alert_d, alert_tgt;
   logic [CW-1:0]   dcnt_q [N];
   logic [CW-1:0]   dcnt_d [N];
   logic            muted_q, muted_d;
   logic [PW-1:0]   phase_q, phase_d;

   logic [W-1:0]    lvl [N];
   logic [SW-1:0]   sum;
   logic            mute_fall;

   logic green_n, yellow_n, critical_n, buzzer_n;

   // State register (all sequential state).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nivel_q     <= '0;
         mute_q      <= 1'b1;
         mute_prev_q <= 1'b1;
         state_q     <= StGreen;
         cand_q      <= StGreen;
         cnt_q       <= '0;
         alert_q     <= '0;
         muted_q     <= 1'b0;
         phase_q     <= '0;
         for (int i = 0; i < N; i++) dcnt_q[i] <= '0;
      end else begin
         nivel_q     <= bus.nivel_n;
         mute_q      <= bus.mute_n;
         mute_prev_q <= mute_q;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         alert_q     <= alert_d;
         muted_q     <= muted_d;
         phase_q     <= phase_d;
         for (int i = 0; i < N; i++) dcnt_q[i] <= dcnt_d[i];
      end
   end

   // Next-state logic.
   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         lvl[i] = ~nivel_q[i*W +: W];
         sum    = sum + SW'(lvl[i]);
      end

      // Worsening moves use raw thresholds, improving moves need the HYST margin.
      target = StGreen;
      case (state_q)
         StGreen: begin
            if (sum < ThC)      target = StCrit;
            else if (sum < ThG) target = StYellow;
            else                target = StGreen;
         end
         StYellow: begin
            if (sum < ThC)          target = StCrit;
            else if (sum >= ThGUp)  target = StGreen;
            else                    target = StYellow;
         end
         StCrit: begin
            if (sum >= ThGUp)       target = StGreen;
            else if (sum >= ThCUp)  target = StYellow;
            else                    target = StCrit;
         end
         default: target = StGreen;
      endcase

      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      if (target == state_q) begin
         cnt_d = '0;
      end else begin
         if (target == cand_q) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cand_d = target;
            cnt_d  = CW'(1);
         end
         if (cnt_d == CW'(DEB)) begin
            state_d = cand_d;
            cnt_d   = '0;
         end
      end

      // Per-channel alert: a two-state version of the same filter.
      alert_d   = alert_q;
      alert_tgt = alert_q;
      for (int i = 0; i < N; i++) begin
         dcnt_d[i] = dcnt_q[i];
         if (alert_q[i]) alert_tgt[i] = !(SW'(lvl[i]) >= ThDUp);
         else            alert_tgt[i] = (SW'(lvl[i]) < ThD);
         if (alert_tgt[i] == alert_q[i]) begin
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + CW'(1);
            if (dcnt_d[i] == CW'(DEB)) begin
               alert_d[i] = alert_tgt[i];
               dcnt_d[i]  = '0;
            end
         end
      end

      // Mute only latches while staying in CRITICAL; leaving or entering clears it.
      mute_fall = mute_prev_q & ~mute_q;
      muted_d   = (state_q == StCrit) && (state_d == StCrit) && (muted_q || mute_fall);

      // Phase is 0 on the entry edge so the first low cycle meets critical_n going low.
      phase_d = '0;
      if ((state_q == StCrit) && (state_d == StCrit)) begin
         if (phase_q == PW'(2 * BUZ_HALF - 1)) phase_d = '0;
         else                                  phase_d = phase_q + PW'(1);
      end
   end

   // Output decode from registered state only.
   always_comb begin
      green_n    = (state_q != StGreen);
      yellow_n   = (state_q != StYellow);
      critical_n = (state_q != StCrit);
      buzzer_n   = !((state_q == StCrit) && !muted_q && (phase_q < PW'(BUZ_HALF)));
   end

   assign bus.green_n    = green_n;
   assign bus.yellow_n   = yellow_n;
   assign bus.critical_n = critical_n;
   assign bus.buzzer_n   = buzzer_n;
   assign bus.descarga_n = ~alert_q;
   assign bus.estado     = state_q;
endmodule

// File: tb/tb_nivelcarga_monitor.sv
// Self-checking bench for nivelcarga_monitor: directed scenarios followed by random level
// and mute activity, all compared every cycle against a history-based reference model.
module tb_nivelcarga_monitor;
   localparam int unsigned N        = 2;
   localparam int unsigned W        = 4;
   localparam int unsigned TH_G     = 16;
   localparam int unsigned TH_C     = 8;
   localparam int unsigned TH_D     = 3;
   localparam int unsigned HYST     = 2;
   localparam int unsigned DEB      = 4;
   localparam int unsigned BUZ_HALF = 8;
   localparam int          LMAX     = (1 << W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nivelcarga_if #(.N(N), .W(W)) bus ();

   nivelcarga_monitor #(
      .N(N), .W(W), .TH_G(TH_G), .TH_C(TH_C), .TH_D(TH_D),
      .HYST(HYST), .DEB(DEB), .BUZ_HALF(BUZ_HALF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: state changes once the last DEB targets (all judged against the
   // current state) agree on a different class; buzzer pattern derived from time in CRITICAL.
   int m_state;
   int m_cap[N];
   bit m_mute_cap, m_mute_prev;
   bit m_alert[N];
   int m_streak[N];
   int m_tq[$];
   bit m_muted;
   int m_age;

   function automatic int classify(input int st, input int s);
      int t;
      t = st;
      if (st == 0)      t = (s < TH_C) ? 2 : (s < TH_G) ? 1 : 0;
      else if (st == 1) t = (s < TH_C) ? 2 : (s >= TH_G + HYST) ? 0 : 1;
      else              t = (s >= TH_G + HYST) ? 0 : (s >= TH_C + HYST) ? 1 : 2;
      return t;
   endfunction

   task automatic model_reset();
      m_state = 0;
      foreach (m_cap[i]) begin
         m_cap[i]    = LMAX;
         m_alert[i]  = 1'b0;
         m_streak[i] = 0;
      end
      m_mute_cap  = 1'b1;
      m_mute_prev = 1'b1;
      m_tq.delete();
      m_muted = 1'b0;
      m_age   = 0;
   endtask

   task automatic model_step();
      int s, tgt, old_st;
      bit same, fall, flip;
      logic [W-1:0] raw;
      old_st = m_state;
      s = 0;
      foreach (m_cap[i]) s += m_cap[i];
      tgt = classify(m_state, s);
      m_tq.push_back(tgt);
      if (m_tq.size() > DEB) void'(m_tq.pop_front());
      if (m_tq.size() == DEB && tgt != m_state) begin
         same = 1'b1;
         foreach (m_tq[j]) if (m_tq[j] != tgt) same = 1'b0;
         if (same) begin
            m_state = tgt;
            m_tq.delete();
         end
      end
      foreach (m_cap[i]) begin
         flip = m_alert[i] ? (m_cap[i] >= TH_D + HYST) : (m_cap[i] < TH_D);
         m_streak[i] = flip ? m_streak[i] + 1 : 0;
         if (m_streak[i] == DEB) begin
            m_alert[i]  = !m_alert[i];
            m_streak[i] = 0;
         end
      end
      fall    = m_mute_prev && !m_mute_cap;
      m_muted = (old_st == 2) && (m_state == 2) && (m_muted || fall);
      if (m_state == 2 && old_st != 2) m_age = 0;
      else if (m_state == 2)           m_age++;
      for (int i = 0; i < N; i++) begin
         raw      = bus.nivel_n[i*W +: W];
         m_cap[i] = LMAX - int'(raw);
      end
      m_mute_prev = m_mute_cap;
      m_mute_cap  = bus.mute_n;
   endtask

   task automatic check_outputs();
      logic [N-1:0] desc;
      bit buz;
      foreach (m_alert[i]) desc[i] = !m_alert[i];
      buz = !(m_state == 2 && !m_muted && (m_age % (2 * BUZ_HALF)) < BUZ_HALF);
      check_eq("estado", 32'(bus.estado), 32'(m_state));
      check_eq("green_n", 32'(bus.green_n), 32'(m_state != 0));
      check_eq("yellow_n", 32'(bus.yellow_n), 32'(m_state != 1));
      check_eq("critical_n", 32'(bus.critical_n), 32'(m_state != 2));
      check_eq("led_onehot", 32'($countones({!bus.green_n, !bus.yellow_n, !bus.critical_n})),
               32'd1);
      check_eq("descarga_n", 32'(bus.descarga_n), 32'(desc));
      check_eq("buzzer_n", 32'(bus.buzzer_n), 32'(buz));
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      check_outputs();
   endtask

   task automatic hold(input int n);
      repeat (n) cycle();
   endtask

   task automatic set_levels(input int l0, input int l1);
      bus.nivel_n = ~{W'(l1), W'(l0)};
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_green"}, 32'(bus.green_n), 32'd0);
      check_eq({tag, "_yellow"}, 32'(bus.yellow_n), 32'd1);
      check_eq({tag, "_crit"}, 32'(bus.critical_n), 32'd1);
      check_eq({tag, "_desc"}, 32'(bus.descarga_n), 32'b11);
      check_eq({tag, "_buz"}, 32'(bus.buzzer_n), 32'd1);
      check_eq({tag, "_estado"}, 32'(bus.estado), 32'd0);
   endtask

   initial begin
      bus.nivel_n = '0;
      bus.mute_n  = 1'b1;
      model_reset();
      #12;
      check_reset_values("rst");
      @(negedge clk);
      rst_n = 1'b1;
      hold(3);
      check_reset_values("rel");

      // GREEN -> YELLOW after DEB edges from capture.
      set_levels(5, 5);
      hold(DEB);
      check_eq("yel_early", 32'(bus.estado), 32'd0);
      hold(1);
      check_eq("yel_enter", 32'(bus.estado), 32'd1);
      check_eq("yel_led", 32'(bus.yellow_n), 32'd0);

      // Short excursion is filtered out.
      set_levels(10, 10);
      hold(3);
      set_levels(5, 5);
      hold(8);
      check_eq("excursion", 32'(bus.estado), 32'd1);

      // Upward hysteresis.
      set_levels(8, 8);
      hold(10);
      check_eq("s16_yel", 32'(bus.estado), 32'd1);
      set_levels(8, 9);
      hold(10);
      check_eq("s17_yel", 32'(bus.estado), 32'd1);
      set_levels(9, 9);
      hold(DEB);
      check_eq("s18_early", 32'(bus.estado), 32'd1);
      hold(1);
      check_eq("s18_green", 32'(bus.estado), 32'd0);

      // Direct GREEN -> CRITICAL with alerts and buzzer.
      set_levels(1, 2);
      hold(DEB);
      check_eq("crit_early", 32'(bus.estado), 32'd0);
      hold(1);
      check_eq("crit_enter", 32'(bus.critical_n), 32'd0);
      check_eq("crit_desc", 32'(bus.descarga_n), 32'b00);
      check_eq("buz_first", 32'(bus.buzzer_n), 32'd0);
      hold(BUZ_HALF - 1);
      check_eq("buz_low_end", 32'(bus.buzzer_n), 32'd0);
      hold(1);
      check_eq("buz_high", 32'(bus.buzzer_n), 32'd1);
      hold(BUZ_HALF);
      check_eq("buz_low2", 32'(bus.buzzer_n), 32'd0);

      // Mute pulse.
      bus.mute_n = 1'b0;
      hold(1);
      bus.mute_n = 1'b1;
      hold(1);
      check_eq("mute_now", 32'(bus.buzzer_n), 32'd1);
      hold(20);
      check_eq("mute_stays", 32'(bus.buzzer_n), 32'd1);

      // Out to YELLOW and back: buzzer restarts.
      set_levels(5, 5);
      hold(DEB + 1);
      check_eq("back_yel", 32'(bus.estado), 32'd1);
      set_levels(1, 2);
      hold(DEB + 1);
      check_eq("reenter_crit", 32'(bus.estado), 32'd2);
      check_eq("reenter_buz", 32'(bus.buzzer_n), 32'd0);

      // Discharge hysteresis on channel 1; channel 0 recovers independently.
      set_levels(15, 2);
      hold(8);
      check_eq("desc_ch0_clr", 32'(bus.descarga_n), 32'b01);
      set_levels(15, 3);
      hold(10);
      check_eq("desc_ch1_hold", 32'(bus.descarga_n[1]), 32'd0);
      set_levels(15, 5);
      hold(DEB);
      check_eq("desc_ch1_early", 32'(bus.descarga_n[1]), 32'd0);
      hold(1);
      check_eq("desc_ch1_clr", 32'(bus.descarga_n), 32'b11);

      // Random phase.
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 2) == 0) set_levels($urandom_range(0, 4), $urandom_range(0, 6));
         else                           set_levels($urandom_range(0, 15), $urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) bus.mute_n = 1'($urandom_range(0, 1));
         hold($urandom_range(1, 8));
      end

      // Asynchronous reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async");
      bus.nivel_n = '0;
      bus.mute_n  = 1'b1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      hold(5);
      for (int seg = 0; seg < 60; seg++) begin
         set_levels($urandom_range(0, 15), $urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) bus.mute_n = 1'($urandom_range(0, 1));
         hold($urandom_range(1, 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/nivelcarga_monitor.md
Name: nivelcarga_monitor

Overview:
- Clocked, parametrised successor to the combinational two-battery charge-level indicator.
- Monitors N battery channels of W bits each and sums their levels.
- Classifies the total into GREEN / YELLOW / CRITICAL with hysteresis and persistence filtering. Raises per-channel discharge alerts and drives a pulsed, mutable buzzer.
- Sits between the board switch inputs and the LED/buzzer pins. All board-facing pins are active-low.

Parameters:
- N, 2, number of battery channels (>=1).
- W, 4, bits per channel level.
- TH_G, 16, total-sum threshold for GREEN (S >= TH_G).
- TH_C, 8, total-sum threshold for CRITICAL (S < TH_C).
- TH_D, 3, per-channel discharge threshold (level < TH_D).
- HYST, 2, hysteresis margin applied to every upward (improving) transition.
- DEB, 4, consecutive cycles a new classification must persist before it is taken (>=1).
- BUZ_HALF, 8, buzzer on/off half-period in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nivel_n  in  N*W  channel levels, active-low; channel i is bits [i*W +: W]; true level = ~bits.
- mute_n  in  1  mute button, active-low, level signal.
- green_n  out  1  GREEN LED, active-low.
- yellow_n  out  1  YELLOW LED, active-low.
- critical_n  out  1  CRITICAL LED, active-low.
- descarga_n  out  N  per-channel discharge alert, active-low.
- buzzer_n  out  1  buzzer drive, active-low.
- estado  out  2  debug state code: 0=GREEN, 1=YELLOW, 2=CRITICAL, 3 never driven.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State GREEN, estado=0.
  - Input register holds true level max on all channels (all bits 0 at pins).
  - All counters 0; mute flag 0; buzzer phase 0.
  - Outputs: green_n=0, yellow_n=1, critical_n=1, descarga_n=all 1, buzzer_n=1.
  - Reset mid-operation forces these values immediately, without waiting for clk.
- Input stage:
  - nivel_n and mute_n are registered every edge.
  - All decisions use the registered copies.
- Sum:
  - S = sum of N true levels, width W+clog2(N)+1, no overflow possible.
  - Thresholds are compared unsigned at that width.
- Target classification from the current state:
  - Downward moves use raw thresholds: S < TH_G leaves GREEN; S < TH_C enters CRITICAL.
  - Upward moves need margin: S >= TH_C+HYST leaves CRITICAL; S >= TH_G+HYST enters GREEN.
  - Direct GREEN<->CRITICAL jumps are allowed.
- Persistence:
  - Hold a candidate and a counter.
  - If target == state: counter=0.
  - Else if target == candidate: counter+1.
  - Else: candidate=target, counter=1.
  - When the counter reaches DEB, state=candidate and counter=0.
  - A new input captured at edge k changes state at edge k+DEB. Outputs are registered from state, with no extra latency.
- LEDs: exactly one of green_n / yellow_n / critical_n is low at any time, after reset and always.
- Discharge, independent per channel:
  - Same persistence counter (DEB) and hysteresis as the state machine.
  - Alert asserts when level < TH_D persists DEB cycles.
  - Alert clears when level >= TH_D+HYST persists DEB cycles.
- Buzzer:
  - Active only in CRITICAL with mute flag 0.
  - On entering CRITICAL, the phase counter restarts.
  - buzzer_n is low for BUZ_HALF cycles, then high for BUZ_HALF cycles, repeating.
  - The first low cycle coincides with critical_n going low.
  - Outside CRITICAL, buzzer_n=1.
- Mute:
  - A falling edge of the registered mute_n while in CRITICAL sets the mute flag.
  - buzzer_n=1 from the next edge.
  - The flag clears when state leaves CRITICAL, so re-entry sounds again.
  - mute_n falling outside CRITICAL is ignored.
  - mute_n held low does not re-trigger.

Test Plan (defaults; channel levels given as true values, pins driven inverted):
- Reset, then release with pins all 0 -> green_n=0, yellow_n=1, critical_n=1, descarga_n=2'b11, buzzer_n=1, estado=0. Asserting rst_n low between edges forces the same values immediately.
- Levels 5,5 (S=10) captured at edge k -> estado=1, yellow_n=0 at edge k+4. A 3-cycle excursion to 10,10 (S=20) then back to 5,5 -> no state change.
- From YELLOW, S=16 then S=17, each held 10 cycles -> stays YELLOW. S=18 held -> GREEN 4 edges after capture.
- Levels 1,2 (S=3) from GREEN -> CRITICAL directly at capture+4. descarga_n=2'b00 at the same edge. buzzer_n low 8 cycles, high 8, repeating, first low on the critical_n-low edge.
- In CRITICAL, 1-cycle low pulse on mute_n -> buzzer_n=1 from the next edge and stays 1. Raising to S=10 (YELLOW) and then returning to S=3 -> buzzer pattern restarts on CRITICAL re-entry.
- Channel 1 at 2, then 3, held -> descarga_n[1] stays 0 (3 < TH_D+HYST=5). At 5 held -> descarga_n[1]=1 after 4 edges. Channel 0 is unaffected.
